fpadd_issuer: RTL and testbench

Request-side sequencer for the floating-point adder control path. It accepts operand pairs from upstream on a valid/ready interface and buffers them in a 2-entry FIFO. It drives the operands and a one-cycle `Go` pulse into the adder, then waits for the adder's level-held `Result` handshake. It captures `Sum` into a single output register presented downstream on valid/ready, with a watchdog that drops an operation whose `Result` never arrives.

---
 rtl/fpadd_issuer.sv | 203 ++++++++++++++++++++
 tb/tb_fpadd_issuer.sv | 530 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpadd_issuer.sv
// fpadd_issuer: request-side sequencer for the floating-point adder.
// Buffers operand pairs in a 2-entry FIFO, issues them to the adder with a
// one-cycle Go pulse, waits for a fresh Result handshake and captures Sum
// into a single output register. A watchdog drops operations whose Result
// never arrives and raises a sticky TimeoutErr.
// Optional feature: define FPADD_ISSUER_ZERO_BYPASS_EN to resolve pairs with
// a zero operand directly in IDLE, without involving the adder.
module fpadd_issuer #(
  parameter int EXPBITS      = 8,
  parameter int MANTISSABITS = 23,
  parameter int WIDTH        = 1 + EXPBITS + MANTISSABITS,
  parameter int TIMEOUT      = 64
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InA,
  input  logic [WIDTH-1:0] InB,
  output logic [WIDTH-1:0] OpA,
  output logic [WIDTH-1:0] OpB,
  output logic             Go,
  input  logic             Result,
  input  logic [WIDTH-1:0] Sum,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutSum,
  output logic             TimeoutErr,
  input  logic             ErrClr,
  output logic             Busy
);

  localparam int              CNTW    = $clog2(TIMEOUT);
  localparam logic [CNTW-1:0] WD_LAST = CNTW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAITLOW  = 2'd2,
    WAITHIGH = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [WIDTH-1:0]  fifo_a [2];
  logic [WIDTH-1:0]  fifo_b [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic [WIDTH-1:0]  head_a;
  logic [WIDTH-1:0]  head_b;

  logic [CNTW-1:0]   wd_cnt;

  logic              push;
  logic              pop;
  logic              capture;
  logic              expire;
  logic              bypass;
  logic [WIDTH-1:0]  bypass_sum;

  assign head_a  = fifo_a[rd_ptr];
  assign head_b  = fifo_b[rd_ptr];

  // InReady looks only at the registered count, never at a same-cycle pop.
  assign InReady = (count != 2'd2);
  assign push    = InValid && InReady;
  assign pop     = capture || expire || bypass;

  assign OpA     = (count != 2'd0) ? head_a : '0;
  assign OpB     = (count != 2'd0) ? head_b : '0;
  assign Go      = (state == ISSUE);
  assign Busy    = (state != IDLE) || (count != 2'd0);

`ifdef FPADD_ISSUER_ZERO_BYPASS_EN
  localparam int MAGW = EXPBITS + MANTISSABITS;

  // Zero means exponent and mantissa clear; the sign bit is ignored.
  logic a_zero;
  logic b_zero;
  assign a_zero = (head_a[MAGW-1:0] == '0);
  assign b_zero = (head_b[MAGW-1:0] == '0);
`endif

  // State register.
  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge values of its peers, independent of process ordering.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-cycle control decisions.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nxt  = state;
    capture    = 1'b0;
    expire     = 1'b0;
    bypass     = 1'b0;
    bypass_sum = '0;
    case (state)
      IDLE: begin
        if (count != 2'd0 && !OutValid) begin
`ifdef FPADD_ISSUER_ZERO_BYPASS_EN
          if (a_zero) begin
            bypass     = 1'b1;
            bypass_sum = head_b;
          end else if (b_zero) begin
            bypass     = 1'b1;
            bypass_sum = head_a;
          end else begin
            state_nxt  = ISSUE;
          end
`else
          state_nxt = ISSUE;
`endif
        end
      end
      ISSUE: state_nxt = WAITLOW;
      WAITLOW: begin
        // A Result still high here belongs to the previous operation.
        if (wd_cnt == WD_LAST) begin
          expire    = 1'b1;
          state_nxt = IDLE;
        end else if (!Result) begin
          state_nxt = WAITHIGH;
        end
      end
      WAITHIGH: begin
        // A capture on the expiry cycle takes priority over the watchdog.
        if (Result) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end else if (wd_cnt == WD_LAST) begin
          expire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Watchdog: zeroed while issuing, counts every waiting cycle.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wd_cnt <= '0;
    end else if (state == ISSUE) begin
      wd_cnt <= '0;
    end else if (state == WAITLOW || state == WAITHIGH) begin
      wd_cnt <= wd_cnt + CNTW'(1);
    end
  end

  // Operand storage, written on push only.
  // NOTE: the storage array has no reset; count qualifies every read, so
  // stale contents are never observable and need no clearing.
  always_ff @(posedge Clock) begin
    if (push) begin
      fifo_a[wr_ptr] <= InA;
      fifo_b[wr_ptr] <= InB;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count alone.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
    end
  end

  // Output register: loaded by capture or bypass, released by the handshake.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      OutValid <= 1'b0;
      OutSum   <= '0;
    end else if (capture) begin
      OutValid <= 1'b1;
      OutSum   <= Sum;
    end else if (bypass) begin
      OutValid <= 1'b1;
      OutSum   <= bypass_sum;
    end else if (OutValid && OutReady) begin
      OutValid <= 1'b0;
    end
  end

  // Sticky watchdog flag; a new expiry beats a simultaneous clear.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)       TimeoutErr <= 1'b0;
    else if (expire)  TimeoutErr <= 1'b1;
    else if (ErrClr)  TimeoutErr <= 1'b0;
  end

endmodule

// File: tb/tb_fpadd_issuer.sv
// Self-checking bench for fpadd_issuer. Directed scenarios cover reset, the
// basic issue/capture path, FIFO backpressure, stale Result rejection, the
// watchdog and its race with capture, reset mid-operation and the zero
// bypass option; a randomized stream is checked against a queue model.
module tb_fpadd_issuer;

  localparam int W = 32;
  localparam int T = 16;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } pair_t;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         InValid;
  logic         InReady;
  logic [W-1:0] InA;
  logic [W-1:0] InB;
  logic [W-1:0] OpA;
  logic [W-1:0] OpB;
  logic         Go;
  logic         Result;
  logic [W-1:0] Sum;
  logic         OutValid;
  logic         OutReady;
  logic [W-1:0] OutSum;
  logic         TimeoutErr;
  logic         ErrClr;
  logic         Busy;

  int           checks;
  int           failures;
  int           go_cnt;
  bit           prev_go;
  bit           adder_auto;
  int           rem;
  logic [W-1:0] pend_sum;
  pair_t        iss_q[$];
  logic [W-1:0] exp_q[$];

  fpadd_issuer #(.TIMEOUT(T)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .InValid    (InValid),
    .InReady    (InReady),
    .InA        (InA),
    .InB        (InB),
    .OpA        (OpA),
    .OpB        (OpB),
    .Go         (Go),
    .Result     (Result),
    .Sum        (Sum),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .OutSum     (OutSum),
    .TimeoutErr (TimeoutErr),
    .ErrClr     (ErrClr),
    .Busy       (Busy)
  );

  always #5 Clock = ~Clock;

  // Stand-in adder arithmetic; the DUT only forwards whatever Sum carries.
  function automatic logic [W-1:0] add_model(input logic [W-1:0] a, input logic [W-1:0] b);
    return a + b;
  endfunction

  // Advance one edge, observe 1ns later; tracks Go pulses and, when enabled,
  // plays the adder: drop Result on Go, raise it with the sum some cycles later.
  task automatic tick();
    pair_t p;
    @(posedge Clock);
    #1;
    if (Go) begin
      go_cnt++;
      checks++;
      if (prev_go) begin
        failures++;
        $display("FAIL go_pulse_width: Go high on 2 consecutive cycles, required 1");
      end
      if (adder_auto) begin
        checks++;
        if (iss_q.size() == 0) begin
          failures++;
          $display("FAIL issue_order: Go with OpA=%h OpB=%h, required no issue (model empty)", OpA, OpB);
          pend_sum = '0;
        end else begin
          p = iss_q.pop_front();
          pend_sum = add_model(p.a, p.b);
          if (OpA !== p.a || OpB !== p.b) begin
            failures++;
            $display("FAIL issue_operands: OpA=%h OpB=%h, required %h %h", OpA, OpB, p.a, p.b);
          end
        end
        Result = 1'b0;
        rem = $urandom_range(2, 8);
      end
    end else if (adder_auto && rem > 0) begin
      rem--;
      if (rem == 0) begin
        Result = 1'b1;
        Sum    = pend_sum;
      end
    end
    prev_go = Go;
  endtask

  // Present a pair until accepted; optionally record it in the model queues.
  task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b, input bit track);
    int n = 0;
    InValid = 1'b1;
    InA = a;
    InB = b;
    while (!InReady && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!InReady) begin
      failures++;
      $display("FAIL push_timeout: InReady=%b after %0d cycles, required 1", InReady, n);
    end
    if (track) begin
      iss_q.push_back('{a: a, b: b});
      exp_q.push_back(add_model(a, b));
    end
    tick();
    InValid = 1'b0;
  endtask

  // Accept outputs with OutReady high and compare them in order to the model.
  task automatic drain(input int budget, input int gbase, input bit chk_go);
    int n = 0;
    bit first = 1'b1;
    logic [W-1:0] e;
    OutReady = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      if (OutValid) begin
        e = exp_q.pop_front();
        checks++;
        if (OutSum !== e) begin
          failures++;
          $display("FAIL drain_order: OutSum=%h, required %h", OutSum, e);
        end
        if (chk_go && first) begin
          checks++;
          if (go_cnt - gbase != 1) begin
            failures++;
            $display("FAIL go_before_release: Go count=%0d at first handshake, required 1", go_cnt - gbase);
          end
          first = 1'b0;
        end
      end
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d sums outstanding, required 0", exp_q.size());
    end
    OutReady = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; InValid = 1'b0; InA = '0; InB = '0; Result = 1'b0;
    Sum = '0; OutReady = 1'b0; ErrClr = 1'b0;
    #1 Reset = 1'b0;
    #1;
    checks++;
    if ({InReady, Go, OutValid, TimeoutErr, Busy} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_flags: {InReady,Go,OutValid,TimeoutErr,Busy}=%b, required 10000",
               {InReady, Go, OutValid, TimeoutErr, Busy});
    end
    checks++;
    if (OpA !== '0 || OpB !== '0 || OutSum !== '0) begin
      failures++;
      $display("FAIL reset_data: OpA=%h OpB=%h OutSum=%h, required all 0", OpA, OpB, OutSum);
    end
    InValid = 1'b1; InA = 32'h1234_5678; InB = 32'h1111_1111;
    @(posedge Clock);
    #1;
    checks++;
    if (Busy !== 1'b0 || Go !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: Busy=%b Go=%b while held in reset, required 0 0", Busy, Go);
    end
    InValid = 1'b0;
    #3 Reset = 1'b1;
    tick();
    checks++;
    if (InReady !== 1'b1 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: InReady=%b Busy=%b, required 1 0", InReady, Busy);
    end
  endtask

  task automatic test_single_op();
    int g0 = go_cnt;
    Result = 1'b0;
    push_pair(32'h3F80_0000, 32'h4000_0000, 1'b0);
    checks++;
    if (Busy !== 1'b1 || Go !== 1'b0 || OpA !== 32'h3F80_0000 || OpB !== 32'h4000_0000) begin
      failures++;
      $display("FAIL single_accept: Busy=%b Go=%b OpA=%h OpB=%h, required 1 0 3f800000 40000000",
               Busy, Go, OpA, OpB);
    end
    tick();
    checks++;
    if (Go !== 1'b1) begin
      failures++;
      $display("FAIL single_go: Go=%b one cycle after accept, required 1", Go);
    end
    tick();
    checks++;
    if (Go !== 1'b0) begin
      failures++;
      $display("FAIL single_go_end: Go=%b, required 0", Go);
    end
    tick();
    checks++;
    if (OutValid !== 1'b0) begin
      failures++;
      $display("FAIL single_early: OutValid=%b before Result, required 0", OutValid);
    end
    Result = 1'b1;
    Sum    = 32'h4040_0000;
    tick();
    checks++;
    if (OutValid !== 1'b1 || OutSum !== 32'h4040_0000) begin
      failures++;
      $display("FAIL single_capture: OutValid=%b OutSum=%h, required 1 40400000", OutValid, OutSum);
    end
    checks++;
    if (Busy !== 1'b0 || InReady !== 1'b1 || OpA !== '0 || go_cnt - g0 != 1) begin
      failures++;
      $display("FAIL single_idle: Busy=%b InReady=%b OpA=%h Go count=%0d, required 0 1 0 1",
               Busy, InReady, OpA, go_cnt - g0);
    end
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
    checks++;
    if (OutValid !== 1'b0) begin
      failures++;
      $display("FAIL single_release: OutValid=%b after handshake, required 0", OutValid);
    end
  endtask

  task automatic test_backpressure();
    int g0 = go_cnt;
    int n  = 0;
    adder_auto = 1'b1;
    rem = 0;
    OutReady = 1'b0;
    InValid = 1'b1; InA = 32'h3F80_0001; InB = 32'h4000_0001;
    iss_q.push_back('{a: InA, b: InB});
    exp_q.push_back(add_model(InA, InB));
    tick();
    InA = 32'h4110_0000; InB = 32'h4220_0000;
    iss_q.push_back('{a: InA, b: InB});
    exp_q.push_back(add_model(InA, InB));
    tick();
    checks++;
    if (InReady !== 1'b0) begin
      failures++;
      $display("FAIL fifo_full: InReady=%b with 2 entries, required 0", InReady);
    end
    InA = 32'h4330_0000; InB = 32'h4440_0000;
    while (!InReady && n < 50) begin
      tick();
      n++;
    end
    iss_q.push_back('{a: InA, b: InB});
    exp_q.push_back(add_model(InA, InB));
    tick();
    InValid = 1'b0;
    repeat (8) tick();
    checks++;
    if (go_cnt - g0 != 1 || OutValid !== 1'b1 || OutSum !== exp_q[0] || InReady !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_hold: Go count=%0d OutValid=%b OutSum=%h InReady=%b, required 1 1 %h 0",
               go_cnt - g0, OutValid, OutSum, InReady, exp_q[0]);
    end
    drain(200, g0, 1'b1);
    adder_auto = 1'b0;
    rem = 0;
  endtask

  task automatic test_stale_result();
    Result = 1'b1;
    Sum    = 32'hDEAD_BEEF;
    push_pair(32'h4080_0000, 32'h40A0_0000, 1'b0);
    tick();
    checks++;
    if (Go !== 1'b1) begin
      failures++;
      $display("FAIL stale_go: Go=%b, required 1", Go);
    end
    repeat (T) tick();
    checks++;
    if (TimeoutErr !== 1'b0 || OutValid !== 1'b0 || Busy !== 1'b1) begin
      failures++;
      $display("FAIL stale_wait: TimeoutErr=%b OutValid=%b Busy=%b one cycle before expiry, required 0 0 1",
               TimeoutErr, OutValid, Busy);
    end
    tick();
    checks++;
    if (TimeoutErr !== 1'b1 || OutValid !== 1'b0 || Busy !== 1'b0 || InReady !== 1'b1) begin
      failures++;
      $display("FAIL stale_expire: TimeoutErr=%b OutValid=%b Busy=%b InReady=%b, required 1 0 0 1",
               TimeoutErr, OutValid, Busy, InReady);
    end
  endtask

  task automatic test_race();
    ErrClr = 1'b1;
    tick();
    ErrClr = 1'b0;
    checks++;
    if (TimeoutErr !== 1'b0) begin
      failures++;
      $display("FAIL err_clear: TimeoutErr=%b after ErrClr, required 0", TimeoutErr);
    end
    push_pair(32'h40C0_0000, 32'h40E0_0000, 1'b0);
    tick();
    Result = 1'b0;
    repeat (T) tick();
    Result = 1'b1;
    Sum    = 32'h4150_0000;
    tick();
    checks++;
    if (OutValid !== 1'b1 || OutSum !== 32'h4150_0000 || TimeoutErr !== 1'b0) begin
      failures++;
      $display("FAIL race_capture: OutValid=%b OutSum=%h TimeoutErr=%b, required 1 41500000 0",
               OutValid, OutSum, TimeoutErr);
    end
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
  endtask

  task automatic test_err_clr();
    push_pair(32'h4100_0000, 32'h4100_0000, 1'b0);
    tick();
    repeat (T) tick();
    ErrClr = 1'b1;
    tick();
    checks++;
    if (TimeoutErr !== 1'b1) begin
      failures++;
      $display("FAIL err_set_wins: TimeoutErr=%b with ErrClr on expiry, required 1", TimeoutErr);
    end
    tick();
    ErrClr = 1'b0;
    checks++;
    if (TimeoutErr !== 1'b0) begin
      failures++;
      $display("FAIL err_clear_later: TimeoutErr=%b, required 0", TimeoutErr);
    end
  endtask

  task automatic test_reset_midop();
    int g0;
    push_pair(32'h4120_0000, 32'h4130_0000, 1'b0);
    tick();
    Result = 1'b0;
    tick();
    tick();
    checks++;
    if (Busy !== 1'b1) begin
      failures++;
      $display("FAIL midop_busy: Busy=%b while waiting, required 1", Busy);
    end
    #2 Reset = 1'b0;
    #1;
    checks++;
    if ({InReady, Go, OutValid, TimeoutErr, Busy} !== 5'b10000 || OutSum !== '0) begin
      failures++;
      $display("FAIL midop_reset: {InReady,Go,OutValid,TimeoutErr,Busy}=%b OutSum=%h, required 10000 0",
               {InReady, Go, OutValid, TimeoutErr, Busy}, OutSum);
    end
    #2 Reset = 1'b1;
    g0 = go_cnt;
    tick();
    Result = 1'b1;
    Sum    = 32'h4444_4444;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 2) Result = 1'b0;
      checks++;
      if (OutValid !== 1'b0) begin
        failures++;
        $display("FAIL midop_late_result: OutValid=%b after late Result, required 0", OutValid);
      end
    end
    checks++;
    if (go_cnt != g0 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL midop_quiet: Go pulses=%0d Busy=%b, required 0 0", go_cnt - g0, Busy);
    end
  endtask

  task automatic test_zero_bypass();
    int g0 = go_cnt;
    Result = 1'b0;
    push_pair(32'h0000_0000, 32'hC0A0_0000, 1'b0);
`ifdef FPADD_ISSUER_ZERO_BYPASS_EN
    tick();
    checks++;
    if (OutValid !== 1'b1 || OutSum !== 32'hC0A0_0000 || go_cnt != g0 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL bypass_a_zero: OutValid=%b OutSum=%h Go pulses=%0d Busy=%b, required 1 c0a00000 0 0",
               OutValid, OutSum, go_cnt - g0, Busy);
    end
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
    push_pair(32'h4120_0000, 32'h8000_0000, 1'b0);
    tick();
    checks++;
    if (OutValid !== 1'b1 || OutSum !== 32'h4120_0000 || go_cnt != g0) begin
      failures++;
      $display("FAIL bypass_b_zero: OutValid=%b OutSum=%h Go pulses=%0d, required 1 41200000 0",
               OutValid, OutSum, go_cnt - g0);
    end
`else
    tick();
    checks++;
    if (Go !== 1'b1) begin
      failures++;
      $display("FAIL nobypass_go: Go=%b for zero operand, required 1", Go);
    end
    Result = 1'b0;
    tick();
    tick();
    Result = 1'b1;
    Sum    = 32'hC0A0_0000;
    tick();
    checks++;
    if (OutValid !== 1'b1 || OutSum !== 32'hC0A0_0000 || go_cnt - g0 != 1) begin
      failures++;
      $display("FAIL nobypass_capture: OutValid=%b OutSum=%h Go pulses=%0d, required 1 c0a00000 1",
               OutValid, OutSum, go_cnt - g0);
    end
`endif
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
  endtask

  task automatic test_random();
    int           sent = 0;
    int           got  = 0;
    int           n    = 0;
    logic [W-1:0] e;
    logic [W-1:0] a;
    logic [W-1:0] b;
    iss_q.delete();
    exp_q.delete();
    adder_auto = 1'b1;
    rem = 0;
    while ((sent < 40 || exp_q.size() != 0) && n < 4000) begin
      OutReady = ($urandom_range(0, 3) != 0);
      if (OutValid && OutReady) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL random_extra: OutSum=%h, required no output", OutSum);
        end else begin
          e = exp_q.pop_front();
          got++;
          if (OutSum !== e) begin
            failures++;
            $display("FAIL random_sum: OutSum=%h, required %h", OutSum, e);
          end
        end
      end
      if (sent < 40 && $urandom_range(0, 1) == 1) begin
        a = $urandom | 32'h4000_0000;
        b = $urandom | 32'h4000_0000;
        InValid = 1'b1;
        InA = a;
        InB = b;
        if (InReady) begin
          iss_q.push_back('{a: a, b: b});
          exp_q.push_back(add_model(a, b));
          sent++;
        end
      end else begin
        InValid = 1'b0;
      end
      tick();
      n++;
    end
    InValid  = 1'b0;
    OutReady = 1'b0;
    adder_auto = 1'b0;
    checks++;
    if (got != 40 || TimeoutErr !== 1'b0) begin
      failures++;
      $display("FAIL random_total: received=%0d TimeoutErr=%b, required 40 0", got, TimeoutErr);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    go_cnt = 0;
    prev_go = 1'b0;
    adder_auto = 1'b0;
    rem = 0;
    pend_sum = '0;
    test_reset();
    test_single_op();
    test_backpressure();
    test_stale_result();
    test_race();
    test_err_clr();
    test_reset_midop();
    test_zero_bypass();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
